// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// single-ported synchronous RAM. A three-state FSM (idle/access/capture) serves
// one access at a time; ties go to the requester that was not granted last.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   if_req_i, if_addr_i             fetch request (held until if_gnt_o)
//   if_gnt_o, if_valid_o, if_rdata_o  fetch grant pulse, data-valid pulse, word
//   dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i  data request (held until dm_gnt_o)
//   dm_gnt_o, dm_valid_o, dm_rdata_o  data grant pulse, done pulse, loaded word
//   we_o, addr_o, data_o            RAM write enable, address, write data
//   data_i                          RAM read data, one cycle after addr_o
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_valid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StCapture} state_e;

  state_e            state_q, state_d;
  // Owner encoding: 0 = fetch, 1 = data.
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic              write_q, write_d;
  logic              if_gnt_q, if_gnt_d;
  logic              dm_gnt_q, dm_gnt_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              grant_if, grant_dm;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    write_d      = write_q;
    if_gnt_d     = 1'b0;
    dm_gnt_d     = 1'b0;
    if_valid_d   = 1'b0;
    dm_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    // On a tie the fetch port wins only if data owned the previous access.
    grant_if     = if_req_i && (!dm_req_i || last_owner_q);
    grant_dm     = dm_req_i && (!if_req_i || !last_owner_q);

    unique case (state_q)
      StIdle: begin
        if (grant_if) begin
          state_d      = StAccess;
          owner_d      = 1'b0;
          last_owner_d = 1'b0;
          write_d      = 1'b0;
          if_gnt_d     = 1'b1;
          addr_d       = if_addr_i;
        end else if (grant_dm) begin
          state_d      = StAccess;
          owner_d      = 1'b1;
          last_owner_d = 1'b1;
          write_d      = dm_we_i;
          dm_gnt_d     = 1'b1;
          addr_d       = dm_addr_i;
          we_d         = dm_we_i;
          if (dm_we_i) begin
            data_d = dm_wdata_i;
          end
        end
      end
      StAccess: begin
        state_d = StCapture;
      end
      StCapture: begin
        state_d = StIdle;
        if (owner_q) begin
          dm_valid_d = 1'b1;
          if (!write_q) begin
            dm_rdata_d = data_i;
          end
        end else begin
          if_valid_d = 1'b1;
          if_rdata_d = data_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      if_gnt_q     <= 1'b0;
      dm_gnt_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      write_q      <= write_d;
      if_gnt_q     <= if_gnt_d;
      dm_gnt_q     <= dm_gnt_d;
      if_valid_q   <= if_valid_d;
      dm_valid_q   <= dm_valid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign if_gnt_o   = if_gnt_q;
  assign dm_gnt_o   = dm_gnt_q;
  assign if_valid_o = if_valid_q;
  assign dm_valid_o = dm_valid_q;
  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;
  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: test sequences push expected grants and
// read data into queues; a negedge monitor pops and compares as the DUT
// presents grant and valid pulses.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_valid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic        dm_gnt_o, dm_valid_o;
  logic [31:0] dm_rdata_o;
  logic        we_o;
  logic [31:0] addr_o, data_o, data_i;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_valid_o(dm_valid_o),
    .dm_rdata_o(dm_rdata_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
    .data_i(data_i)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model with a few preloaded words.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hCAFE0001;
      mem[8'h24] <= 32'hA5A50002;
    end else if (we_o) begin
      mem[addr_o[7:0]] <= data_o;
    end
    data_i <= mem[addr_o[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        owner;  // 0 fetch, 1 data
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gnt_t;

  gnt_t        exp_gnt[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];
  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int last_gnt_cyc = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (we_o) begin
      we_cnt++;
      chk("we_only_with_dm_gnt", 32'(dm_gnt_o), 32'd1);
    end
    if (if_gnt_o || dm_gnt_o) begin
      gnt_t g;
      chk("gnt_exclusive", 32'(if_gnt_o && dm_gnt_o), 32'd0);
      chk("gnt_spacing_ge3", 32'(cyc - last_gnt_cyc >= 3), 32'd1);
      last_gnt_cyc = cyc;
      if (exp_gnt.size() == 0) begin
        chk("unexpected_gnt", 32'd1, 32'd0);
      end else begin
        g = exp_gnt.pop_front();
        chk("gnt_owner", 32'(dm_gnt_o), 32'(g.owner));
        chk("gnt_addr", addr_o, g.addr);
        chk("gnt_we", 32'(we_o), 32'(g.we));
        if (g.we) chk("gnt_wdata", data_o, g.wdata);
      end
    end
    if (if_valid_o || dm_valid_o) begin
      chk("valid_exclusive", 32'(if_valid_o && dm_valid_o), 32'd0);
      chk("valid_latency", cyc - last_gnt_cyc, 32'd2);
    end
    if (if_valid_o) begin
      if (exp_if.size() == 0) chk("unexpected_if_valid", 32'd1, 32'd0);
      else chk("if_rdata", if_rdata_o, exp_if.pop_front());
    end
    if (dm_valid_o) begin
      if (exp_dm.size() == 0) chk("unexpected_dm_valid", 32'd1, 32'd0);
      else chk("dm_rdata", dm_rdata_o, exp_dm.pop_front());
    end
  end

  task automatic push_gnt(input logic owner, input logic [31:0] a, input logic we,
                          input logic [31:0] wd);
    gnt_t g;
    g.owner = owner; g.addr = a; g.we = we; g.wdata = wd;
    exp_gnt.push_back(g);
  endtask

  task automatic if_access(input logic [31:0] a);
    bit got = 0;
    @(negedge clk);
    if_req_i = 1'b1;
    if_addr_i = a;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (if_gnt_o) got = 1;
    end
    if_req_i = 1'b0;
    if (!got) chk("if_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bit got = 0;
    @(negedge clk);
    dm_req_i = 1'b1;
    dm_we_i = we;
    dm_addr_i = a;
    dm_wdata_i = wd;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dm_gnt_o) got = 1;
    end
    dm_req_i = 1'b0;
    dm_we_i = 1'b0;
    if (!got) chk("dm_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (exp_gnt.size() == 0 && exp_if.size() == 0 && exp_dm.size() == 0) done = 1;
      else @(negedge clk);
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt_valid_we"},
        32'({if_gnt_o, dm_gnt_o, if_valid_o, dm_valid_o, we_o}), 32'd0);
    chk({tag, "_addr_o"}, addr_o, 32'd0);
    chk({tag, "_data_o"}, data_o, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata_o, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata_o, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // Idle: nothing moves for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", 32'({if_gnt_o, dm_gnt_o, if_valid_o, dm_valid_o, we_o}), 32'd0);
    end

    // Fetch only.
    push_gnt(1'b0, 32'h10, 1'b0, 32'h0);
    exp_if.push_back(32'hDEADBEEF);
    if_access(32'h10);
    drain();

    // Data write then read back; dm_rdata_o untouched by the write.
    we_cnt = 0;
    push_gnt(1'b1, 32'h40, 1'b1, 32'h12345678);
    exp_dm.push_back(32'h0);
    dm_access(1'b1, 32'h40, 32'h12345678);
    drain();
    chk("write_we_cycles", we_cnt, 32'd1);
    push_gnt(1'b1, 32'h40, 1'b0, 32'h0);
    exp_dm.push_back(32'h12345678);
    dm_access(1'b0, 32'h40, 32'h0);
    drain();

    // Tie, data owned last: fetch first.
    push_gnt(1'b0, 32'h20, 1'b0, 32'h0);
    push_gnt(1'b1, 32'h40, 1'b0, 32'h0);
    exp_if.push_back(32'hCAFE0001);
    exp_dm.push_back(32'h12345678);
    fork
      if_access(32'h20);
      dm_access(1'b0, 32'h40, 32'h0);
    join
    drain();

    // Repeat tie: fetch first again, data write leaves dm_rdata_o alone.
    push_gnt(1'b0, 32'h24, 1'b0, 32'h0);
    push_gnt(1'b1, 32'h44, 1'b1, 32'h0BADF00D);
    exp_if.push_back(32'hA5A50002);
    exp_dm.push_back(32'h12345678);
    fork
      if_access(32'h24);
      dm_access(1'b1, 32'h44, 32'h0BADF00D);
    join
    drain();

    // Lone fetch makes fetch the last owner, so the next tie goes to data.
    push_gnt(1'b0, 32'h10, 1'b0, 32'h0);
    exp_if.push_back(32'hDEADBEEF);
    if_access(32'h10);
    drain();
    push_gnt(1'b1, 32'h44, 1'b0, 32'h0);
    push_gnt(1'b0, 32'h20, 1'b0, 32'h0);
    exp_dm.push_back(32'h0BADF00D);
    exp_if.push_back(32'hCAFE0001);
    fork
      if_access(32'h20);
      dm_access(1'b0, 32'h44, 32'h0);
    join
    drain();

    // Data request rising during the fetch access waits for the next idle.
    push_gnt(1'b0, 32'h24, 1'b0, 32'h0);
    push_gnt(1'b1, 32'h10, 1'b0, 32'h0);
    exp_if.push_back(32'hA5A50002);
    exp_dm.push_back(32'hDEADBEEF);
    fork
      if_access(32'h24);
      begin
        @(negedge clk);
        dm_access(1'b0, 32'h10, 32'h0);
      end
    join
    drain();

    // Reset during capture of a fetch: no valid pulse, outputs cleared.
    push_gnt(1'b0, 32'h10, 1'b0, 32'h0);
    if_access(32'h10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("abort");
    repeat (3) @(negedge clk);

    // Normal fetch afterwards.
    push_gnt(1'b0, 32'h20, 1'b0, 32'h0);
    exp_if.push_back(32'hCAFE0001);
    if_access(32'h20);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, RAM address width.
REQ-002 Parameter DATA_W, 32, RAM data width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req_i  in  1  fetch read request; held with if_addr_i until if_gnt_o.
REQ-006 if_addr_i  in  ADDR_W  fetch address.
REQ-007 if_gnt_o  out  1  one-cycle pulse: fetch request accepted.
REQ-008 if_valid_o  out  1  one-cycle pulse: if_rdata_o valid.
REQ-009 if_rdata_o  out  DATA_W  fetched word.
REQ-010 dm_req_i  in  1  data request; held with dm_we_i/dm_addr_i/dm_wdata_i until dm_gnt_o.
REQ-011 dm_we_i  in  1  1 = write, 0 = read.
REQ-012 dm_addr_i  in  ADDR_W  data address.
REQ-013 dm_wdata_i  in  DATA_W  store data.
REQ-014 dm_gnt_o  out  1  one-cycle pulse: data request accepted.
REQ-015 dm_valid_o  out  1  one-cycle pulse: read data valid or write complete.
REQ-016 dm_rdata_o  out  DATA_W  loaded word.
REQ-017 we_o  out  1  RAM write enable.
REQ-018 addr_o  out  ADDR_W  RAM address.
REQ-019 data_o  out  DATA_W  RAM write data.
REQ-020 data_i  in  DATA_W  RAM read data, valid one cycle after addr_o is presented.

Function
REQ-021 FSM states IDLE, ACCESS, CAPTURE; all outputs registered.
REQ-022 Requests sampled only in IDLE; in ACCESS/CAPTURE request inputs are ignored.
REQ-023 IDLE, exactly one req high -> grant that requester, go to ACCESS.
REQ-024 IDLE, both high -> grant the requester not granted last (last_owner flag); fetch wins the first tie after reset.
REQ-025 IDLE, no req -> stay IDLE; we_o 0; addr_o/data_o hold.
REQ-026 Grant at edge E0: in cycle after E0 (ACCESS) addr_o = granted addr, gnt_o of owner = 1, we_o = dm_we_i for data owner (0 for fetch), data_o = dm_wdata_i on data write.
REQ-027 ACCESS -> CAPTURE unconditionally; we_o and gnt_o return to 0 in CAPTURE.
REQ-028 CAPTURE -> IDLE; on that edge owner's rdata_o <= data_i (reads only); owner's valid_o = 1 for the following cycle only.
REQ-029 Data write: dm_valid_o pulses with same timing as a read; dm_rdata_o unchanged.
REQ-030 Latency: gnt pulse 1 cycle after request sampled; valid pulse 3 cycles after sampling; max throughput one access per 3 cycles.
REQ-031 Requester deasserts req in the cycle after seeing gnt; req still high in the next IDLE is a new request.
REQ-032 At most one of if_gnt_o/dm_gnt_o, and one of if_valid_o/dm_valid_o, is high in any cycle.
REQ-033 we_o is high only in ACCESS with data owner and dm_we_i sampled high.
REQ-034 Requester continuously asserting while other waits: strict alternation (no starvation).

Reset
REQ-035 reset high at an edge -> next cycle: state IDLE, last_owner = data, all outputs (gnt, valid, rdata, we_o, addr_o, data_o) 0.
REQ-036 reset in ACCESS or CAPTURE aborts the access: no valid pulse issued; a write already sampled by RAM is not undone.
REQ-037 reset dominates any simultaneous request.

Verification
REQ-038 Fetch only: if_req_i=1, if_addr_i=0x10, RAM[0x10]=0xDEADBEEF -> if_gnt_o pulse cycle 1, addr_o=0x10, if_valid_o pulse cycle 3 with if_rdata_o=0xDEADBEEF.
REQ-039 Data write then read: write 0x12345678 to 0x40 -> we_o=1 for exactly one cycle, dm_valid_o pulse; read 0x40 -> dm_rdata_o=0x12345678.
REQ-040 Tie after reset: both req same cycle -> fetch granted first, data granted in next IDLE; repeat tie -> alternates fetch, data, fetch.
REQ-041 Request arriving in ACCESS/CAPTURE: dm_req_i rises during fetch access -> no dm_gnt_o until the IDLE cycle, then granted.
REQ-042 Reset in CAPTURE of a read -> no valid pulse, all outputs 0 next cycle, subsequent fetch completes normally.
REQ-043 Idle: no requests for 10 cycles -> we_o, gnt, valid all stay 0.
